// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Buffers register writebacks (dest reg, data) and retires them, one per
//   cycle, through a registered output stage that drives RegComp's single
//   write port. Lookup ports report whether a register still has a write in
//   flight (queued, or sitting in the output stage with RegWrite=1).
//
//   Optional feature macro: REG_WB_FWD_EN
//     defined   -> fwd_a/fwd_b ports exist and carry the youngest pending value
//     undefined -> only hit_a/hit_b are provided; the controller stalls on hit
//
//   Handshake: a push transfers on a rising edge where push_valid && push_ready.
//   The producer keeps push_reg/push_data stable while push_valid && !push_ready.
//   push_ready depends only on the queue occupancy (never on push_valid or on a
//   same-cycle retire), so a full queue refuses a push even while it drains.
//   A push to register 0 completes the handshake but is discarded.

module reg_writeback_queue #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [AW-1:0]              push_reg,
  input  logic [DW-1:0]              push_data,
  input  logic                       wb_stall,
  output logic                       RegWrite,
  output logic [AW-1:0]              wr_reg,
  output logic [DW-1:0]              writedata,
  input  logic [AW-1:0]              look_a,
  input  logic [AW-1:0]              look_b,
  output logic                       hit_a,
  output logic                       hit_b,
`ifdef REG_WB_FWD_EN
  output logic [DW-1:0]              fwd_a,
  output logic [DW-1:0]              fwd_b,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Queue storage and bookkeeping
  logic [AW-1:0] mem_reg_q  [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Output stage towards RegComp
  logic          regwrite_q,  regwrite_d;
  logic [AW-1:0] wr_reg_q,    wr_reg_d;
  logic [DW-1:0] writedata_q, writedata_d;

  // Per-cycle control
  logic full;
  logic push_accept;
  logic pop;

  // Lookup over the output stage first, then queue entries oldest to
  // youngest, so the youngest match is the one that survives.
  function automatic logic lookup_hit(input logic [AW-1:0] r);
    logic h;
    h = 1'b0;
    if (r != '0) begin
      if (regwrite_q && (wr_reg_q == r)) h = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count_q) && (mem_reg_q[rd_ptr_q + PW'(i)] == r)) h = 1'b1;
      end
    end
    return h;
  endfunction

`ifdef REG_WB_FWD_EN
  function automatic logic [DW-1:0] lookup_data(input logic [AW-1:0] r);
    logic [DW-1:0] d;
    d = '0;
    if (r != '0) begin
      if (regwrite_q && (wr_reg_q == r)) d = writedata_q;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count_q) && (mem_reg_q[rd_ptr_q + PW'(i)] == r)) begin
          d = mem_data_q[rd_ptr_q + PW'(i)];
        end
      end
    end
    return d;
  endfunction
`endif

  // Handshake and retire decisions from the current occupancy only
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    push_accept = push_valid && !full && (push_reg != '0);
    pop         = (count_q != '0) && !wb_stall;
  end

  // Next-state for pointers, occupancy and the output stage
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    regwrite_d  = 1'b0;
    wr_reg_d    = wr_reg_q;
    writedata_d = writedata_q;

    if (push_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      regwrite_d  = 1'b1;
      wr_reg_d    = mem_reg_q[rd_ptr_q];
      writedata_d = mem_data_q[rd_ptr_q];
    end

    unique case ({push_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output-stage registers; reset discards everything in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      regwrite_q  <= 1'b0;
      wr_reg_q    <= '0;
      writedata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      regwrite_q  <= regwrite_d;
      wr_reg_q    <= wr_reg_d;
      writedata_q <= writedata_d;
    end
  end

  // Entry storage: write the tail slot on an accepted push
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg_q[i]  <= '0;
        mem_data_q[i] <= '0;
      end
    end else if (push_accept) begin
      mem_reg_q[wr_ptr_q]  <= push_reg;
      mem_data_q[wr_ptr_q] <= push_data;
    end
  end

  // Output assignments and lookup results
  always_comb begin
    push_ready = !full;
    RegWrite   = regwrite_q;
    wr_reg     = wr_reg_q;
    writedata  = writedata_q;
    count      = count_q;
    hit_a      = lookup_hit(look_a);
    hit_b      = lookup_hit(look_b);
`ifdef REG_WB_FWD_EN
    fwd_a      = lookup_data(look_a);
    fwd_b      = lookup_data(look_b);
`endif
  end

  // Occupancy can never exceed the storage
  a_count_bound : assert property (@(posedge CLK) disable iff (!RST_N)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue
//   Randomized bench with a queue-level reference model: pending writebacks
//   are held as a plain queue, the output stage as three variables, and every
//   accepted push is also appended to a retirement scoreboard.

module tb_reg_writeback_queue;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLK;
  logic          RST_N;
  logic          push_valid;
  logic          push_ready;
  logic [AW-1:0] push_reg;
  logic [DW-1:0] push_data;
  logic          wb_stall;
  logic          RegWrite;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] writedata;
  logic [AW-1:0] look_a;
  logic [AW-1:0] look_b;
  logic          hit_a;
  logic          hit_b;
`ifdef REG_WB_FWD_EN
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
`endif
  logic [CW-1:0] count;

  reg_writeback_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_reg   (push_reg),
    .push_data  (push_data),
    .wb_stall   (wb_stall),
    .RegWrite   (RegWrite),
    .wr_reg     (wr_reg),
    .writedata  (writedata),
    .look_a     (look_a),
    .look_b     (look_b),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
`ifdef REG_WB_FWD_EN
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
`endif
    .count      (count)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL timeout: bench did not reach its summary, actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [AW+DW-1:0] mq[$];     // pending entries, oldest first
  logic             m_rw;      // output-stage model
  logic [AW-1:0]    m_wr_reg;
  logic [DW-1:0]    m_wdata;
  logic [AW+DW-1:0] exp_q[$];  // retirement scoreboard

  int n_vec;
  int n_err;

  function automatic void model_clear();
    mq.delete();
    exp_q.delete();
    m_rw     = 1'b0;
    m_wr_reg = '0;
    m_wdata  = '0;
  endfunction

  // Youngest pending value wins; output stage only counts while it is writing.
  function automatic void model_lookup(input logic [AW-1:0] r, output logic h,
                                       output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (r != 0) begin
      if (m_rw && m_wr_reg == r) begin
        h = 1'b1;
        d = m_wdata;
      end
      foreach (mq[i]) begin
        if (mq[i][AW+DW-1:DW] == r) begin
          h = 1'b1;
          d = mq[i][DW-1:0];
        end
      end
    end
  endfunction

  // One clock edge: the model consumes the inputs present before the edge.
  task automatic tick();
    logic rdy, acc, pop_now;
    rdy     = (mq.size() < DEPTH);
    acc     = push_valid && rdy && (push_reg != 0);
    pop_now = (mq.size() > 0) && !wb_stall;
    @(posedge CLK);
    if (pop_now) begin
      m_rw     = 1'b1;
      m_wr_reg = mq[0][AW+DW-1:DW];
      m_wdata  = mq[0][DW-1:0];
      void'(mq.pop_front());
    end else begin
      m_rw = 1'b0;
    end
    if (acc) begin
      mq.push_back({push_reg, push_data});
      exp_q.push_back({push_reg, push_data});
    end
    @(negedge CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite actual=%0b required=0", RegWrite); end
    n_vec++; if (wr_reg !== '0) begin n_err++; $display("FAIL reset_wr_reg actual=%0h required=0", wr_reg); end
    n_vec++; if (writedata !== '0) begin n_err++; $display("FAIL reset_writedata actual=%0h required=0", writedata); end
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL reset_count actual=%0d required=0", count); end
    n_vec++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL reset_push_ready actual=%0b required=1", push_ready); end
    n_vec++; if (hit_a !== 1'b0 || hit_b !== 1'b0) begin n_err++; $display("FAIL reset_hit actual=%0b%0b required=00", hit_a, hit_b); end
  endtask

  task automatic test_in_order();
    logic [AW-1:0] t_reg  [3];
    logic [DW-1:0] t_data [3];
    int seen;
    t_reg[0] = 4'd1; t_data[0] = 16'h0F0F;
    t_reg[1] = 4'd2; t_data[1] = 16'hF0F0;
    t_reg[2] = 4'd3; t_data[2] = 16'hAAAA;
    seen = 0;
    wb_stall = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        push_valid = 1'b1; push_reg = t_reg[c]; push_data = t_data[c];
      end else begin
        push_valid = 1'b0;
      end
      #1;
      n_vec++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL order_ready c=%0d actual=%0b required=1", c, push_ready); end
      tick();
      n_vec++; if (RegWrite !== (c >= 1 && c <= 3)) begin n_err++; $display("FAIL order_regwrite c=%0d actual=%0b required=%0b", c, RegWrite, (c >= 1 && c <= 3)); end
      if (RegWrite === 1'b1 && seen < 3) begin
        n_vec++;
        if (wr_reg !== t_reg[seen] || writedata !== t_data[seen]) begin
          n_err++; $display("FAIL order_data n=%0d actual=%0d/%0h required=%0d/%0h", seen, wr_reg, writedata, t_reg[seen], t_data[seen]);
        end
        seen++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    n_vec++; if (seen != 3) begin n_err++; $display("FAIL order_count_writes actual=%0d required=3", seen); end
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL order_final_count actual=%0d required=0", count); end
  endtask

  task automatic test_stall_full();
    logic [AW+DW-1:0] ent [5];
    logic [AW+DW-1:0] last;
    int pushed, nret;
    logic fire;
    for (int i = 0; i < 5; i++) ent[i] = {AW'($urandom_range(1, 15)), DW'($urandom)};
    pushed = 0; nret = 0; last = '0;
    wb_stall = 1'b1;
    for (int c = 0; c < 7; c++) begin
      push_valid = 1'b1; {push_reg, push_data} = ent[pushed];
      #1;
      n_vec++; if (push_ready !== (pushed < 4)) begin n_err++; $display("FAIL full_ready c=%0d actual=%0b required=%0b", c, push_ready, (pushed < 4)); end
      fire = push_ready;
      tick();
      if (fire) pushed++;
      n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL full_stalled_regwrite actual=%0b required=0", RegWrite); end
    end
    n_vec++; if (count !== CW'(4)) begin n_err++; $display("FAIL full_count actual=%0d required=4", count); end
    n_vec++; if (push_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low actual=%0b required=0", push_ready); end
    wb_stall = 1'b0;
    for (int c = 0; c < 20; c++) begin
      push_valid = (pushed < 5);
      if (pushed < 5) {push_reg, push_data} = ent[pushed];
      #1;
      n_vec++; if (push_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL drain_ready c=%0d actual=%0b required=%0b", c, push_ready, (mq.size() < DEPTH)); end
      fire = push_valid && push_ready;
      tick();
      if (fire) pushed++;
      n_vec++; if (RegWrite !== m_rw) begin n_err++; $display("FAIL drain_regwrite c=%0d actual=%0b required=%0b", c, RegWrite, m_rw); end
      if (RegWrite === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL drain_extra_write actual=%0h required=none", {wr_reg, writedata});
        end else begin
          if ({wr_reg, writedata} !== exp_q[0]) begin
            n_err++; $display("FAIL drain_order actual=%0h required=%0h", {wr_reg, writedata}, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        nret++; last = {wr_reg, writedata};
      end
      if (pushed == 5 && mq.size() == 0 && !m_rw) break;
    end
    n_vec++; if (nret != 5) begin n_err++; $display("FAIL full_retired actual=%0d required=5", nret); end
    n_vec++; if (last !== ent[4]) begin n_err++; $display("FAIL full_last actual=%0h required=%0h", last, ent[4]); end
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL full_end_count actual=%0d required=0", count); end
  endtask

  task automatic test_lookup_youngest();
    logic h;
    logic [DW-1:0] d;
    wb_stall = 1'b1;
    look_a = 4'd4; look_b = 4'd9;
    push_valid = 1'b1; push_reg = 4'd4; push_data = 16'h1111;
    tick();
    push_data = 16'h2222;
    tick();
    push_valid = 1'b0;
    #1;
    n_vec++; if (hit_a !== 1'b1) begin n_err++; $display("FAIL look_hit actual=%0b required=1", hit_a); end
    n_vec++; if (hit_b !== 1'b0) begin n_err++; $display("FAIL look_miss actual=%0b required=0", hit_b); end
`ifdef REG_WB_FWD_EN
    n_vec++; if (fwd_a !== 16'h2222) begin n_err++; $display("FAIL look_fwd actual=%0h required=2222", fwd_a); end
    n_vec++; if (fwd_b !== 16'h0000) begin n_err++; $display("FAIL look_fwd_miss actual=%0h required=0", fwd_b); end
`endif
    wb_stall = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      model_lookup(look_a, h, d);
      n_vec++; if (hit_a !== h) begin n_err++; $display("FAIL look_track c=%0d actual=%0b required=%0b", c, hit_a, h); end
`ifdef REG_WB_FWD_EN
      n_vec++; if (fwd_a !== d) begin n_err++; $display("FAIL look_track_fwd c=%0d actual=%0h required=%0h", c, fwd_a, d); end
`endif
      tick();
      if (RegWrite === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0 || {wr_reg, writedata} !== exp_q[0]) begin
          n_err++; $display("FAIL look_retire actual=%0h required=%0h", {wr_reg, writedata}, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    #1;
    n_vec++; if (hit_a !== 1'b0) begin n_err++; $display("FAIL look_cleared actual=%0b required=0", hit_a); end
  endtask

  task automatic test_r0_drop();
    wb_stall = 1'b0;
    look_b = 4'd0;
    push_valid = 1'b1; push_reg = 4'd0; push_data = 16'hBEEF;
    #1;
    n_vec++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready actual=%0b required=1", push_ready); end
    n_vec++; if (hit_b !== 1'b0) begin n_err++; $display("FAIL r0_hit actual=%0b required=0", hit_b); end
    tick();
    push_valid = 1'b0;
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL r0_count actual=%0d required=0", count); end
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL r0_regwrite c=%0d actual=%0b required=0", c, RegWrite); end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    wb_stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      push_valid = 1'b1; push_reg = AW'($urandom_range(1, 15)); push_data = DW'($urandom);
      tick();
    end
    push_valid = 1'b0;
    look_a = m_wr_reg;
    n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL rst_pre_regwrite actual=%0b required=1", RegWrite); end
    RST_N = 1'b0;
    #2;
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rst_async_regwrite actual=%0b required=0", RegWrite); end
    n_vec++; if (wr_reg !== '0 || writedata !== '0) begin n_err++; $display("FAIL rst_async_out actual=%0h required=0", {wr_reg, writedata}); end
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL rst_async_count actual=%0d required=0", count); end
    n_vec++; if (hit_a !== 1'b0) begin n_err++; $display("FAIL rst_async_hit actual=%0b required=0", hit_a); end
    RST_N = 1'b1;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++; if (RegWrite !== 1'b0 || count !== '0) begin n_err++; $display("FAIL rst_after c=%0d actual=%0b/%0d required=0/0", c, RegWrite, count); end
    end
  endtask

  task automatic test_random_wrap();
    logic h;
    logic [DW-1:0] d;
    logic fire;
    wb_stall = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      push_valid = 1'b1; push_reg = AW'($urandom_range(1, 15)); push_data = DW'($urandom);
      tick();
    end
    n_vec++; if (count !== CW'(DEPTH)) begin n_err++; $display("FAIL rand_fill actual=%0d required=%0d", count, DEPTH); end
    fire = 1'b1;
    for (int c = 0; c < 24; c++) begin
      push_valid = 1'b1;
      if (fire) begin
        push_reg = AW'($urandom_range(0, 15)); push_data = DW'($urandom);
      end
      wb_stall = ($urandom_range(0, 2) == 0);
      look_a = AW'($urandom_range(0, 15));
      look_b = (mq.size() > 0) ? mq[mq.size()-1][AW+DW-1:DW] : AW'($urandom_range(0, 15));
      #1;
      n_vec++; if (push_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rand_ready c=%0d actual=%0b required=%0b", c, push_ready, (mq.size() < DEPTH)); end
      n_vec++; if (count !== CW'(mq.size())) begin n_err++; $display("FAIL rand_count c=%0d actual=%0d required=%0d", c, count, mq.size()); end
      model_lookup(look_a, h, d);
      n_vec++; if (hit_a !== h) begin n_err++; $display("FAIL rand_hit_a c=%0d actual=%0b required=%0b", c, hit_a, h); end
`ifdef REG_WB_FWD_EN
      n_vec++; if (fwd_a !== d) begin n_err++; $display("FAIL rand_fwd_a c=%0d actual=%0h required=%0h", c, fwd_a, d); end
`endif
      model_lookup(look_b, h, d);
      n_vec++; if (hit_b !== h) begin n_err++; $display("FAIL rand_hit_b c=%0d actual=%0b required=%0b", c, hit_b, h); end
`ifdef REG_WB_FWD_EN
      n_vec++; if (fwd_b !== d) begin n_err++; $display("FAIL rand_fwd_b c=%0d actual=%0h required=%0h", c, fwd_b, d); end
`endif
      fire = push_ready;
      tick();
      n_vec++; if (RegWrite !== m_rw) begin n_err++; $display("FAIL rand_regwrite c=%0d actual=%0b required=%0b", c, RegWrite, m_rw); end
      if (RegWrite === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0 || {wr_reg, writedata} !== exp_q[0]) begin
          n_err++; $display("FAIL rand_retire c=%0d actual=%0h required=%0h", c, {wr_reg, writedata}, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    push_valid = 1'b0;
    wb_stall = 1'b0;
    for (int c = 0; c < DEPTH + 3; c++) begin
      tick();
      if (RegWrite === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0 || {wr_reg, writedata} !== exp_q[0]) begin
          n_err++; $display("FAIL rand_drain actual=%0h required=%0h", {wr_reg, writedata}, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_lost actual=%0d required=0 writes outstanding", exp_q.size()); end
    n_vec++; if (count !== '0 || RegWrite !== 1'b0) begin n_err++; $display("FAIL rand_idle actual=%0d/%0b required=0/0", count, RegWrite); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    RST_N = 1'b0;
    push_valid = 1'b0;
    push_reg = '0;
    push_data = '0;
    wb_stall = 1'b0;
    look_a = '0;
    look_b = '0;
    model_clear();
    #1;
    test_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    test_in_order();
    test_stall_full();
    test_lookup_youngest();
    test_r0_drop();
    test_reset_mid_burst();
    test_random_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
